fp16_add_seq: RTL and testbench
===============================

# fp16_add_seq

Multicycle sequencer for half-precision add/subtract, sitting between the datapath register operands and the combinational `fp_adder16` stage. It accepts two FP16 operands on a start pulse, resolves special cases (zero, denormal flush, Inf, NaN), and drives the adder with registered operands. It then captures the adder's raw sum, repairs overflow and exponent-underflow wrap, and returns a registered result plus status flags after a fixed latency.

## Interface
- `W`, 16: FP16 word width (1 sign, 5 exponent, 10 mantissa bits); fixed.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: request; sampled only in IDLE.
- `op_sub` input 1: 1 computes a−b, 0 computes a+b.
- `a`, `b` input 16: FP16 operands; sampled with `start`.
- `add_a`, `add_b` output 16: registered operands to the external combinational adder.
- `add_sum` input 16: adder output; sampled in the ADD state.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse; `result` and `flags` are valid from this cycle on.
- `result` output 16: final FP16 value; held until the next `done`.
- `flags` output 4: {nan, inf, underflow, zero}; held like `result`.

## Operation
- FSM states: IDLE → CLASS → ADD → WB → IDLE; no other transitions.
- IDLE with `start`=1:
  - Latch `a` into `ra`.
  - Latch `b` into `rb`, with its sign inverted when `op_sub`=1.
  - Go to CLASS.
- IDLE with `start`=0: stay in IDLE.
- `start` while `busy` is ignored; the operands are not latched.
- CLASS:
  - Classify `ra` and `rb`. Exponent 0 is treated as zero (denormals flushed, mantissa discarded). Exponent 31 with mantissa 0 is Inf. Exponent 31 with mantissa ≠ 0 is NaN.
  - Register the special-case code and the value `emax = max(exp_a, exp_b)`.
  - Drive `add_a` = `ra` and `add_b` = `rb`, both registered. They are held until the next CLASS.
- ADD: register `add_sum` into `rs`.
- WB: register `result` and `flags` using the first matching rule:
  - 1. Either operand NaN, or Inf plus Inf of opposite sign → 16'h7E00, nan=1.
  - 2. Exactly one Inf, or two Inf of the same sign → that Inf, inf=1.
  - 3. Both operands zero → sign = AND of both signs, magnitude 0, zero=1.
  - 4. Exactly one operand zero → the other operand unchanged. For zero+b with op_sub, this is the sign-flipped `rb`.
  - 5. `rs[14:0]`==0 (exact cancellation) → 16'h0000, zero=1.
  - 6. `rs` exponent > `emax`+1, compared in 6 bits (normalisation wrapped below 1) → 16'h0000, underflow=1, zero=1.
  - 7. `rs` exponent == 31 (from finite operands) → {`rs`[15], 5'h1F, 10'h0}, inf=1.
  - 8. Otherwise → `rs`, all flags 0.
- Flags not named by the applied rule are 0.
- `done` is set to 1 in WB and cleared in the following cycle.

## Timing
- Reset values (asynchronous): state IDLE, `busy` 0, `done` 0, `result` 16'h0000, `flags` 4'h0, `add_a` 16'h0000, `add_b` 16'h0000.
- Reset mid-operation aborts the operation with no `done`, and all outputs take their reset values.
- `start` is sampled at edge 0. `result`, `flags` and `done` update at edge 3. Latency is 3 clocks.
- `busy` is high after edge 0 through edge 3. `busy` is low in the `done` cycle.
- Back-to-back operation: `start` asserted in the `done` cycle is accepted. The throughput is one operation per 4 cycles.
- `add_a` and `add_b` are stable from edge 1 through edge 2. The external adder therefore has one full cycle of combinational path before ADD samples `add_sum`.
- `result` and `flags` keep their previous value between `done` pulses, including while `busy` is high.

## Structure
- Shared package `fp16_pkg`:
  - Field constants: `EXP_W`=5, `MAN_W`=10, `EXP_MAX`=5'h1F.
  - `QNAN`=16'h7E00.
  - Flag bit indices.
  - State enum.
  - Special-case code enum.
- Sub-module `fp16_classify`, combinational. It takes one 16-bit input and outputs `is_zero`, `is_inf`, `is_nan` and `exp`. It is instantiated twice in CLASS.
- The adder stays outside this block and connects through `add_a`, `add_b` and `add_sum`.

## Test plan
- a=3C00, b=3C00, op_sub=0 → after 3 clocks, `result`=4000 and `flags`=0000; `done` is high for exactly one cycle.
- a=3C00, b=3C00, op_sub=1 → `result`=0000 and `flags`=0001.
- a=7BFF, b=7BFF, op_sub=0 → `result`=7C00 and `flags`=0100. a=7C00, b=7C00, op_sub=1 → `result`=7E00 and `flags`=1000.
- Denormal and underflow:
  - a=0400, b=03FF, op_sub=1 → `result`=0400 (b flushed to zero), `flags`=0000.
  - a=0401, b=0400, op_sub=1 → `result`=0000 and `flags`=0011.
- `start` pulses again at edges 1 and 2 with different operands → they are ignored, and the first result is returned at edge 3. A new `start` in the `done` cycle → its result appears 3 clocks later.
- `reset` asserted asynchronously between edges 1 and 2 → outputs go to reset values immediately, and no `done` follows. The next `start` completes normally.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared FP16 field constants, flag indices and FSM/special-case encodings
// for the half-precision add/subtract sequencer.
package fp16_pkg;

    localparam int W     = 16;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;

    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;
    localparam logic [W-1:0]     QNAN    = 16'h7E00;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_UF   = 1;
    localparam int FLAG_INF  = 2;
    localparam int FLAG_NAN  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLASS = 2'd1,
        ST_ADD   = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        SC_NONE      = 3'd0,
        SC_NAN       = 3'd1,
        SC_INF_A     = 3'd2,
        SC_INF_B     = 3'd3,
        SC_ZERO_BOTH = 3'd4,
        SC_ZERO_A    = 3'd5,
        SC_ZERO_B    = 3'd6
    } spec_e;

    function automatic logic [EXP_W-1:0] exp_field(input logic [W-1:0] x);
        return x[W-2 -: EXP_W];
    endfunction

endpackage

// File: rtl/fp16_classify.sv
// Combinational FP16 operand classifier; denormals count as zero.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [W-1:0]     x,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan,
    output logic [EXP_W-1:0] exp
);

    logic man_nz_s;

    // Field decode and class flags
    always_comb begin
        exp      = exp_field(x);
        man_nz_s = (x[MAN_W-1:0] != 10'h000);
        is_zero  = (exp == 5'h00);
        is_inf   = (exp == EXP_MAX) && !man_nz_s;
        is_nan   = (exp == EXP_MAX) && man_nz_s;
    end

endmodule

// File: rtl/fp16_add_seq.sv
// Four-state sequencer around an external combinational FP16 adder: latches
// operands, resolves special cases, and repairs the adder's raw sum.
module fp16_add_seq
    import fp16_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W-1:0] add_sum,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    state_e           state_q, state_d;
    spec_e            code_q, code_d;
    logic [W-1:0]     ra_q, ra_d, rb_q, rb_d, rs_q, rs_d;
    logic [W-1:0]     add_a_q, add_a_d, add_b_q, add_b_d;
    logic [W-1:0]     result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [EXP_W-1:0] emax_q, emax_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;
    logic [EXP_W-1:0] a_exp_s, b_exp_s, rs_exp_s;

    fp16_classify u_class_a (
        .x       (ra_q),
        .is_zero (a_zero_s),
        .is_inf  (a_inf_s),
        .is_nan  (a_nan_s),
        .exp     (a_exp_s)
    );

    fp16_classify u_class_b (
        .x       (rb_q),
        .is_zero (b_zero_s),
        .is_inf  (b_inf_s),
        .is_nan  (b_nan_s),
        .exp     (b_exp_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed ring, start honoured only in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_CLASS : ST_IDLE;
            ST_CLASS: state_d = ST_ADD;
            ST_ADD:   state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values per state
    always_comb begin
        ra_d     = ra_q;
        rb_d     = rb_q;
        rs_d     = rs_q;
        code_d   = code_q;
        emax_d   = emax_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        result_d = result_q;
        flags_d  = flags_q;
        rs_exp_s = exp_field(rs_q);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_q == ST_WB);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ra_d = a;
                    rb_d = {b[W-1] ^ op_sub, b[W-2:0]};
                end else begin
                    ra_d = ra_q;
                end
            end
            ST_CLASS: begin
                add_a_d = ra_q;
                add_b_d = rb_q;
                emax_d  = (a_exp_s > b_exp_s) ? a_exp_s : b_exp_s;
                if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (ra_q[W-1] != rb_q[W-1]))) begin
                    code_d = SC_NAN;
                end else if (a_inf_s) begin
                    code_d = SC_INF_A;
                end else if (b_inf_s) begin
                    code_d = SC_INF_B;
                end else if (a_zero_s && b_zero_s) begin
                    code_d = SC_ZERO_BOTH;
                end else if (a_zero_s) begin
                    code_d = SC_ZERO_A;
                end else if (b_zero_s) begin
                    code_d = SC_ZERO_B;
                end else begin
                    code_d = SC_NONE;
                end
            end
            ST_ADD: begin
                rs_d = add_sum;
            end
            ST_WB: begin
                flags_d = 4'h0;
                case (code_q)
                    SC_NAN: begin
                        result_d           = QNAN;
                        flags_d[FLAG_NAN]  = 1'b1;
                    end
                    SC_INF_A: begin
                        result_d           = ra_q;
                        flags_d[FLAG_INF]  = 1'b1;
                    end
                    SC_INF_B: begin
                        result_d           = rb_q;
                        flags_d[FLAG_INF]  = 1'b1;
                    end
                    SC_ZERO_BOTH: begin
                        result_d           = {ra_q[W-1] & rb_q[W-1], 15'h0000};
                        flags_d[FLAG_ZERO] = 1'b1;
                    end
                    SC_ZERO_A: begin
                        result_d = rb_q;
                    end
                    SC_ZERO_B: begin
                        result_d = ra_q;
                    end
                    default: begin
                        // A sum exponent above emax+1 means the adder's
                        // normalising shift wrapped the exponent below 1.
                        if (rs_q[W-2:0] == 15'h0000) begin
                            result_d           = 16'h0000;
                            flags_d[FLAG_ZERO] = 1'b1;
                        end else if ({1'b0, rs_exp_s} > ({1'b0, emax_q} + 6'd1)) begin
                            result_d           = 16'h0000;
                            flags_d[FLAG_UF]   = 1'b1;
                            flags_d[FLAG_ZERO] = 1'b1;
                        end else if (rs_exp_s == EXP_MAX) begin
                            result_d           = {rs_q[W-1], EXP_MAX, 10'h000};
                            flags_d[FLAG_INF]  = 1'b1;
                        end else begin
                            result_d = rs_q;
                        end
                    end
                endcase
            end
            default: begin
                ra_d = ra_q;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra_q     <= 16'h0000;
            rb_q     <= 16'h0000;
            rs_q     <= 16'h0000;
            code_q   <= SC_NONE;
            emax_q   <= 5'h00;
            add_a_q  <= 16'h0000;
            add_b_q  <= 16'h0000;
            result_q <= 16'h0000;
            flags_q  <= 4'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rs_q     <= rs_d;
            code_q   <= code_d;
            emax_q   <= emax_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign add_a  = add_a_q;
    assign add_b  = add_b_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp16_add_seq.sv
// Scoreboard bench for fp16_add_seq with a behavioural external adder and a
// rule-level reference model; a monitor pops expectations on every done.
module tb_fp16_add_seq;

    logic        clk, reset, start, op_sub, busy, done;
    logic [15:0] a, b, add_a, add_b, add_sum, result;
    logic [3:0]  flags;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        logic [15:0] aa;
        logic [15:0] ab;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [15:0] last_res = 16'h0000;
    logic [3:0]  last_flg = 4'h0;
    logic        prev_done = 1'b0;

    fp16_add_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op_sub  (op_sub),
        .a       (a),
        .b       (b),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_sum (add_sum),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .flags   (flags)
    );

    // Naive truncating adder: exponent wraps modulo 32 when normalising left.
    function automatic logic [15:0] fp_add_ref(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] big, sml;
        int eb, es, mb, ms, m, e, sh;
        if (x[14:0] >= y[14:0]) begin big = x; sml = y; end
        else begin big = y; sml = x; end
        eb = int'(big[14:10]);
        es = int'(sml[14:10]);
        mb = ((eb != 0) ? 1024 : 0) + int'(big[9:0]);
        ms = ((es != 0) ? 1024 : 0) + int'(sml[9:0]);
        sh = eb - es;
        ms = (sh > 11) ? 0 : (ms >> sh);
        m  = (big[15] == sml[15]) ? (mb + ms) : (mb - ms);
        e  = eb;
        if (m == 0) return 16'h0000;
        if (m >= 2048) begin
            m = m >> 1;
            e = e + 1;
        end else begin
            for (int i = 0; i < 11; i++) begin
                if (m < 1024) begin
                    m = m * 2;
                    e = e - 1;
                end
            end
        end
        return {big[15], e[4:0], m[9:0]};
    endfunction

    assign add_sum = fp_add_ref(add_a, add_b);

    function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib, input logic sub);
        exp_t r;
        logic [15:0] rb, s;
        int ea, eb, es, emax;
        logic an, ai, az, bn, bi, bz;
        rb = {ib[15] ^ sub, ib[14:0]};
        ea = int'(ia[14:10]);
        eb = int'(rb[14:10]);
        an = (ea == 31) && (ia[9:0] != 0);
        ai = (ea == 31) && (ia[9:0] == 0);
        az = (ea == 0);
        bn = (eb == 31) && (rb[9:0] != 0);
        bi = (eb == 31) && (rb[9:0] == 0);
        bz = (eb == 0);
        emax = (ea > eb) ? ea : eb;
        r.aa = ia;
        r.ab = rb;
        r.due = 0;
        r.flg = 4'b0000;
        if (an || bn || (ai && bi && ia[15] != rb[15])) begin r.res = 16'h7E00; r.flg = 4'b1000; end
        else if (ai) begin r.res = ia; r.flg = 4'b0100; end
        else if (bi) begin r.res = rb; r.flg = 4'b0100; end
        else if (az && bz) begin r.res = {ia[15] & rb[15], 15'h0}; r.flg = 4'b0001; end
        else if (az) r.res = rb;
        else if (bz) r.res = ia;
        else begin
            s  = fp_add_ref(ia, rb);
            es = int'(s[14:10]);
            if (s[14:0] == 15'h0) begin r.res = 16'h0000; r.flg = 4'b0001; end
            else if (es > emax + 1) begin r.res = 16'h0000; r.flg = 4'b0011; end
            else if (es == 31) begin r.res = {s[15], 5'h1F, 10'h0}; r.flg = 4'b0100; end
            else r.res = s;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic sub, input bit push);
        exp_t e;
        a = ia; b = ib; op_sub = sub; start = 1'b1;
        if (push) begin
            e = model(ia, ib, sub);
            e.due = cyc + 4;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'h0, busy}, 32'h1);
    endtask

    function automatic logic [15:0] rnd_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 9))
            0: v[14:0] = 15'h0;
            1: v[14:10] = 5'h00;
            2: v[14:0] = 15'h7C00;
            3: begin v[14:10] = 5'h1F; if (v[9:0] == 10'h0) v[0] = 1'b1; end
            default: v[14:10] = 5'($urandom_range(1, 30));
        endcase
        return v;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: pop and compare on done, check holding between dones
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_res  = 16'h0000;
            last_flg  = 4'h0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                chk("done_width", {31'h0, prev_done}, 32'h0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("result", {16'h0, result}, {16'h0, e.res});
                    chk("flags", {28'h0, flags}, {28'h0, e.flg});
                    chk("add_a", {16'h0, add_a}, {16'h0, e.aa});
                    chk("add_b", {16'h0, add_b}, {16'h0, e.ab});
                    chk("latency", cyc, e.due);
                    chk("busy_in_done", {31'h0, busy}, 32'h0);
                    last_res = e.res;
                    last_flg = e.flg;
                end
            end else begin
                chk("result_hold", {16'h0, result}, {16'h0, last_res});
                chk("flags_hold", {28'h0, flags}, {28'h0, last_flg});
            end
            prev_done = done;
        end
    end

    logic [15:0] da [8] = '{16'h3C00, 16'h3C00, 16'h7BFF, 16'h7C00, 16'h0400, 16'h0401, 16'h0000, 16'h8000};
    logic [15:0] db [8] = '{16'h3C00, 16'h3C00, 16'h7BFF, 16'h7C00, 16'h03FF, 16'h0400, 16'h4500, 16'h0000};
    logic        ds [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        logic [15:0] ra, rb;
        reset = 1'b1; start = 1'b0; op_sub = 1'b0; a = 16'h0; b = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_result", {16'h0, result}, 32'h0);
        chk("rst_flags", {28'h0, flags}, 32'h0);
        chk("rst_add_a", {16'h0, add_a}, 32'h0);
        chk("rst_add_b", {16'h0, add_b}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases, issued back to back in each done cycle
        for (int i = 0; i < 8; i++) begin
            issue(da[i], db[i], ds[i], 1'b1);
            repeat (3) @(negedge clk);
        end

        // Starts during busy must be ignored
        issue(16'h4000, 16'h3C00, 1'b0, 1'b1);
        a = 16'h5555; b = 16'h1234; op_sub = 1'b1; start = 1'b1;
        @(negedge clk);
        a = 16'h7E01; b = 16'h7C00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);

        // Asynchronous reset between edges 1 and 2 aborts the operation
        issue(16'h4200, 16'h4400, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_result", {16'h0, result}, 32'h0);
        chk("abort_flags", {28'h0, flags}, 32'h0);
        chk("abort_add_a", {16'h0, add_a}, 32'h0);
        chk("abort_add_b", {16'h0, add_b}, 32'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        issue(16'h3C00, 16'h4000, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Randomised back-to-back stream
        for (int i = 0; i < 300; i++) begin
            ra = rnd_op();
            rb = ($urandom_range(0, 4) == 0) ? ra : rnd_op();
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
            repeat (3) @(negedge clk);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'h0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
